// File: rtl/gpio_bram_loader.sv
// GPIO command decoder feeding the three line BRAMs of the convolution datapath.
// Commands arrive under a toggle req/ack handshake; each one runs IDLE -> EXEC -> ACK.
module gpio_bram_loader #(
   parameter int GPIO_D     = 32,
   parameter int RAM_WIDTH  = 13,
   parameter int NB_ADDRESS = 10,
   parameter int NB_IMAGE   = 10,
   parameter int DEF_LENGTH = 10
) (
   input  logic                  i_CLK,
   input  logic                  i_reset,
   input  logic [GPIO_D-1:0]     i_gpio,
   output logic                  o_ack,
   output logic [2:0]            o_wrEnable,
   output logic [NB_ADDRESS-1:0] o_writeAdd,
   output logic [RAM_WIDTH-1:0]  o_data,
   output logic [NB_IMAGE-1:0]   o_imgLength,
   output logic                  o_loaded,
   output logic                  o_error
);

   typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

   localparam logic [1:0] OP_NOP    = 2'd0;
   localparam logic [1:0] OP_SETLEN = 2'd1;
   localparam logic [1:0] OP_WRITE  = 2'd2;
   localparam logic [1:0] OP_CLEAR  = 2'd3;

   state_t                          r_state, w_next;
   logic [1:0]                      r_op;
   logic [1:0]                      r_bank;
   logic [RAM_WIDTH-1:0]            r_payload;
   logic [2:0][NB_ADDRESS-1:0]      r_cnt;
   logic                            r_ack;
   logic [2:0]                      r_wrEnable;
   logic [NB_ADDRESS-1:0]           r_writeAdd;
   logic [RAM_WIDTH-1:0]            r_data;
   logic [NB_IMAGE-1:0]             r_len;
   logic                            r_loaded;
   logic                            r_error;

   logic                            w_pending;
   logic [NB_ADDRESS-1:0]           w_cur;
   logic                            w_room;
   logic                            w_full;
   logic                            w_unused;

   assign w_pending = (i_gpio[31] != r_ack);
   assign w_unused  = ^{i_gpio[26:RAM_WIDTH+8], i_gpio[7:0]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pending) w_next = EXEC;
         EXEC:    w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Counter of the addressed bank; bank 3 is rejected before w_room is used.
   always_comb begin
      w_cur = r_cnt[0];
      case (r_bank)
         2'd1:    w_cur = r_cnt[1];
         2'd2:    w_cur = r_cnt[2];
         default: w_cur = r_cnt[0];
      endcase
   end

   assign w_room = (NB_IMAGE'(w_cur) < r_len);
   assign w_full = (r_len != '0) &&
                   (NB_IMAGE'(r_cnt[0]) == r_len) &&
                   (NB_IMAGE'(r_cnt[1]) == r_len) &&
                   (NB_IMAGE'(r_cnt[2]) == r_len);

   always_ff @(posedge i_CLK or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_op       <= OP_NOP;
         r_bank     <= 2'd0;
         r_payload  <= '0;
         r_cnt      <= '0;
         r_ack      <= 1'b0;
         r_wrEnable <= 3'b000;
         r_writeAdd <= '0;
         r_data     <= '0;
         r_len      <= NB_IMAGE'(DEF_LENGTH);
         r_loaded   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_wrEnable <= 3'b000;
         r_loaded   <= w_full;
         if (r_state == IDLE && w_pending) begin
            r_op      <= i_gpio[30:29];
            r_bank    <= i_gpio[28:27];
            r_payload <= i_gpio[RAM_WIDTH+7:8];
         end
         if (r_state == ACK) r_ack <= ~r_ack;
         if (r_state == EXEC) begin
            case (r_op)
               OP_SETLEN: begin
                  r_len    <= r_payload[NB_IMAGE-1:0];
                  r_cnt    <= '0;
                  r_loaded <= 1'b0;
                  r_error  <= 1'b0;
               end
               OP_WRITE: begin
                  if (r_bank == 2'd3 || !w_room) begin
                     r_error <= 1'b1;
                  end else begin
                     for (int b = 0; b < 3; b++) begin
                        if (r_bank == b[1:0]) begin
                           r_wrEnable[b] <= 1'b1;
                           r_cnt[b]      <= r_cnt[b] + 1'b1;
                        end
                     end
                     r_writeAdd <= w_cur;
                     r_data     <= r_payload;
                  end
               end
               OP_CLEAR: begin
                  r_cnt    <= '0;
                  r_loaded <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_ack       = r_ack;
   assign o_wrEnable  = r_wrEnable;
   assign o_writeAdd  = r_writeAdd;
   assign o_data      = r_data;
   assign o_imgLength = r_len;
   assign o_loaded    = r_loaded;
   assign o_error     = r_error;

endmodule

// File: tb/tb_gpio_bram_loader.sv
// Bench for gpio_bram_loader: transaction-level model feeds an expected-write queue,
// a negedge monitor pops and compares every BRAM strobe.
module tb_gpio_bram_loader;

   logic        clk;
   logic        rst;
   logic [31:0] gpio;
   logic        o_ack;
   logic [2:0]  o_wrEnable;
   logic [9:0]  o_writeAdd;
   logic [12:0] o_data;
   logic [9:0]  o_imgLength;
   logic        o_loaded;
   logic        o_error;

   gpio_bram_loader dut (
      .i_CLK       (clk),
      .i_reset     (rst),
      .i_gpio      (gpio),
      .o_ack       (o_ack),
      .o_wrEnable  (o_wrEnable),
      .o_writeAdd  (o_writeAdd),
      .o_data      (o_data),
      .o_imgLength (o_imgLength),
      .o_loaded    (o_loaded),
      .o_error     (o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  b;
      logic [9:0]  a;
      logic [12:0] d;
   } wr_t;

   wr_t q[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   // Reference state: what the loader should hold after each completed command.
   int  m_len;
   int  m_cnt[3];
   bit  m_err;
   bit  ack_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_loaded();
      return (m_len != 0) && (m_cnt[0] == m_len) && (m_cnt[1] == m_len) && (m_cnt[2] == m_len);
   endfunction

   task automatic m_reset();
      m_len = 10; m_cnt = '{0, 0, 0}; m_err = 0; ack_exp = 0;
   endtask

   task automatic model(input logic [1:0] op, input logic [1:0] b, input logic [12:0] p);
      wr_t w;
      case (op)
         2'd1: begin m_len = int'(p[9:0]); m_cnt = '{0, 0, 0}; m_err = 0; end
         2'd2: begin
            if (b == 2'd3) m_err = 1;
            else if (m_cnt[b] < m_len) begin
               w.b = b; w.a = 10'(m_cnt[b]); w.d = p;
               q.push_back(w);
               m_cnt[b]++;
            end else m_err = 1;
         end
         2'd3: m_cnt = '{0, 0, 0};
         default: ;
      endcase
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_error"},  32'(o_error),     32'(m_err));
      chk({tag, "_loaded"}, 32'(o_loaded),    32'(m_loaded()));
      chk({tag, "_len"},    32'(o_imgLength), 32'(m_len));
   endtask

   task automatic send(input logic [1:0] op, input logic [1:0] b, input logic [12:0] p);
      @(posedge clk); #1;
      gpio = {~ack_exp, op, b, 6'($urandom), p, 8'($urandom)};
      model(op, b, p);
      @(posedge clk); #1;
      gpio[30:0] = 31'($urandom);
      @(posedge clk); #1;
      chk("ack_hold", 32'(o_ack), 32'(ack_exp));
      @(posedge clk); #1;
      ack_exp = ~ack_exp;
      chk("ack_toggle", 32'(o_ack), 32'(ack_exp));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, 32'(o_ack),       32'd0);
      chk({tag, "_we"},  32'(o_wrEnable),  32'd0);
      chk({tag, "_add"}, 32'(o_writeAdd),  32'd0);
      chk({tag, "_dat"}, 32'(o_data),      32'd0);
      chk({tag, "_len"}, 32'(o_imgLength), 32'd10);
      chk({tag, "_ld"},  32'(o_loaded),    32'd0);
      chk({tag, "_err"}, 32'(o_error),     32'd0);
   endtask

   // Monitor: every strobe cycle must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (!rst && o_wrEnable != 3'b000) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", 32'(o_wrEnable), 32'd0);
         end else begin
            wr_t w;
            w = q.pop_front();
            chk("wr_enable", 32'(o_wrEnable), 32'(3'b001 << w.b));
            chk("wr_addr",   32'(o_writeAdd), 32'(w.a));
            chk("wr_data",   32'(o_data),     32'(w.d));
         end
      end
   end

   initial begin
      gpio = 32'h0;
      rst  = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("por");
      rst = 1'b0;

      // Length 4, bank 1 fill with payloads 1..4
      send(2'd1, 2'd0, 13'd4);
      chk_state("setlen");
      for (int i = 1; i <= 4; i++) send(2'd2, 2'd1, 13'(i));
      chk_state("bank1");

      // Complete banks 0 and 2, then overflow bank 0
      for (int i = 0; i < 4; i++) begin
         send(2'd2, 2'd0, 13'(16'h100 + i));
         send(2'd2, 2'd2, 13'(16'h200 + i));
      end
      chk_state("full");
      send(2'd2, 2'd0, 13'h0ABC);
      chk_state("overflow");

      // Bank 3 write flags error; SETLEN clears it
      send(2'd1, 2'd0, 13'd4);
      send(2'd2, 2'd3, 13'h1FFF);
      chk_state("bank3");
      send(2'd1, 2'd0, 13'd5);
      chk_state("errclr");

      // CLEAR after two bank-2 writes restarts addressing at 0
      send(2'd2, 2'd2, 13'h0011);
      send(2'd2, 2'd2, 13'h0022);
      send(2'd3, 2'd0, 13'd0);
      send(2'd2, 2'd2, 13'h0033);
      chk_state("clear");

      // NOP and zero-length: every write is rejected
      send(2'd0, 2'd1, 13'h1234);
      send(2'd1, 2'd0, 13'd0);
      send(2'd2, 2'd1, 13'h0055);
      chk_state("zerolen");

      // Double toggle: first word is a write, second (toggled back) is a NOP
      send(2'd1, 2'd0, 13'd3);
      begin
         bit a0;
         a0 = ack_exp;
         @(posedge clk); #1;
         gpio = {~a0, 2'd2, 2'd0, 6'd0, 13'h0777, 8'd0};
         model(2'd2, 2'd0, 13'h0777);
         @(posedge clk); #1;
         gpio = {a0, 2'd0, 2'd0, 6'd0, 13'h0, 8'd0};
         repeat (6) @(posedge clk);
         #1 chk("dbl_ack", 32'(o_ack), 32'(a0));
         chk_state("dbl");
      end

      // Reset during EXEC: command discarded, no strobe
      @(posedge clk); #1;
      gpio = {~ack_exp, 2'd2, 2'd1, 6'd0, 13'h0999, 8'd0};
      @(posedge clk); #2;
      rst = 1'b1;
      m_reset();
      #1 chk_reset_outputs("rst_exec");
      gpio = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_state("post_rst");

      // Randomized traffic against the model
      send(2'd1, 2'd0, 13'($urandom_range(1, 6)));
      for (int i = 0; i < 60; i++) begin
         int r;
         logic [1:0] op;
         r  = $urandom_range(0, 19);
         op = (r < 14) ? 2'd2 : (r < 16) ? 2'd3 : (r < 18) ? 2'd0 : 2'd1;
         if (op == 2'd1) send(op, 2'd0, 13'($urandom_range(0, 7)));
         else            send(op, 2'($urandom_range(0, 3)), 13'($urandom));
         chk_state("rand");
      end

      // Mid-cycle async reset with state loaded
      send(2'd1, 2'd0, 13'd2);
      send(2'd2, 2'd3, 13'd1);
      @(posedge clk); #3;
      rst = 1'b1;
      m_reset();
      #1 chk_reset_outputs("async");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      #1 chk("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
